pi1_rr_arbiter: RTL and testbench

- Shares one PI1 slave port (typically a pi1-to-wishbone bridge or memory controller) among MSTRCOUNT PI1 masters.
- Round-robin grant with a burst limit.
- A preempted master's pending op is parked in a per-master hold register, so no PI1 handshake is ever violated.
- Sits between cores/DMA masters and the shared bus bridge.

---
 rtl/pi1_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_pi1_rr_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pi1_rr_arbiter.sv
// pi1_rr_arbiter: round-robin PI1 arbiter with a burst limit.
// Preempted ops wait in per-master park regs until regranted.
module pi1_rr_arbiter #(
  parameter  int ARCHBITSZ = 32,
  parameter  int MSTRCOUNT = 2,
  parameter  int MAXBURST  = 8,
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8),
  localparam int SELBITSZ  = ARCHBITSZ / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [2*MSTRCOUNT-1:0]         m_op_i,
  input  logic [ADDRBITSZ*MSTRCOUNT-1:0] m_addr_i,
  input  logic [ARCHBITSZ*MSTRCOUNT-1:0] m_data_i,
  input  logic [SELBITSZ*MSTRCOUNT-1:0]  m_sel_i,
  output logic [ARCHBITSZ*MSTRCOUNT-1:0] m_data_o,
  output logic [MSTRCOUNT-1:0]           m_rdy_o,
  output logic [1:0]                     s_op_o,
  output logic [ADDRBITSZ-1:0]           s_addr_o,
  output logic [ARCHBITSZ-1:0]           s_data_o,
  output logic [SELBITSZ-1:0]            s_sel_o,
  input  logic [ARCHBITSZ-1:0]           s_data_i,
  input  logic                           s_rdy_i
);

  localparam int GW = $clog2(MSTRCOUNT);
  localparam int BW = $clog2(MAXBURST + 2);
  localparam logic [BW-1:0] BLIM =
    (MAXBURST > 0) ? BW'(MAXBURST - 1) : '0;
  localparam logic [1:0] OP_NOOP = 2'b00;

  logic [1:0]           op_a   [MSTRCOUNT];
  logic [ADDRBITSZ-1:0] addr_a [MSTRCOUNT];
  logic [ARCHBITSZ-1:0] data_a [MSTRCOUNT];
  logic [SELBITSZ-1:0]  sel_a  [MSTRCOUNT];

  logic [1:0]           park_op   [MSTRCOUNT];
  logic [ADDRBITSZ-1:0] park_addr [MSTRCOUNT];
  logic [ARCHBITSZ-1:0] park_data [MSTRCOUNT];
  logic [SELBITSZ-1:0]  park_sel  [MSTRCOUNT];
  logic [MSTRCOUNT-1:0] park_vld;

  logic [GW-1:0]        gnt;
  logic [BW-1:0]        burst_cnt;
  logic                 fresh;

  logic [MSTRCOUNT-1:0] req;
  logic [GW-1:0]        nxt;
  logic                 other;
  logic [1:0]           cur_op;
  logic                 lim_hit;
  logic                 is_park;
  logic                 is_idle;
  logic                 is_pre;
  logic                 is_fwd;

  for (genvar j = 0; j < MSTRCOUNT; j++) begin : g_port
    assign op_a[j]   = m_op_i[2*j +: 2];
    assign addr_a[j] = m_addr_i[ADDRBITSZ*j +: ADDRBITSZ];
    assign data_a[j] = m_data_i[ARCHBITSZ*j +: ARCHBITSZ];
    assign sel_a[j]  = m_sel_i[SELBITSZ*j +: SELBITSZ];
    assign req[j]    = (op_a[j] != OP_NOOP) || park_vld[j];
    assign m_data_o[ARCHBITSZ*j +: ARCHBITSZ] =
      m_rdy_o[j] ? s_data_i : '0;
  end

  assign cur_op  = op_a[gnt];
  assign lim_hit = (MAXBURST != 0) && (burst_cnt >= BLIM);
  assign is_park = fresh && park_vld[gnt];
  assign is_idle = !is_park && (cur_op == OP_NOOP);
  assign is_pre  = !is_park && (cur_op != OP_NOOP)
                && lim_hit && other;
  assign is_fwd  = !is_park && (cur_op != OP_NOOP)
                && !(lim_hit && other);

  // next requester after gnt, scanning with wrap-around
  always_comb begin
    logic [GW-1:0] ji;
    int idx;
    nxt   = gnt;
    other = 1'b0;
    idx   = 0;
    ji    = '0;
    for (int k = 1; k < MSTRCOUNT; k++) begin
      idx = int'(gnt) + k;
      if (idx >= MSTRCOUNT) idx = idx - MSTRCOUNT;
      ji = GW'(idx);
      if (!other && req[ji]) begin
        nxt   = ji;
        other = 1'b1;
      end
    end
  end

  // slave mux and ready steering, zero added latency
  always_comb begin
    m_rdy_o  = '0;
    s_op_o   = OP_NOOP;
    s_addr_o = addr_a[gnt];
    s_data_o = data_a[gnt];
    s_sel_o  = sel_a[gnt];
    if (!rst_i) begin
      unique case (1'b1)
        is_park: begin
          s_op_o   = park_op[gnt];
          s_addr_o = park_addr[gnt];
          s_data_o = park_data[gnt];
          s_sel_o  = park_sel[gnt];
        end
        is_idle, is_pre: begin
          m_rdy_o[gnt] = s_rdy_i;
        end
        is_fwd: begin
          s_op_o       = cur_op;
          m_rdy_o[gnt] = s_rdy_i;
        end
        default: ;
      endcase
    end
  end

  // grant, burst and park bookkeeping; frozen while slave stalls
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt       <= '0;
      burst_cnt <= '0;
      fresh     <= 1'b0;
      park_vld  <= '0;
    end else if (s_rdy_i) begin
      unique case (1'b1)
        is_park: begin
          park_vld[gnt] <= 1'b0;
          fresh         <= 1'b0;
          burst_cnt     <= BW'(1);
        end
        is_idle: begin
          burst_cnt <= '0;
          fresh     <= other;
          if (other) gnt <= nxt;
        end
        is_pre: begin
          park_vld[gnt] <= 1'b1;
          gnt           <= nxt;
          burst_cnt     <= '0;
          fresh         <= 1'b1;
        end
        is_fwd: begin
          fresh <= 1'b0;
          if ((MAXBURST != 0) && (burst_cnt < BLIM))
            burst_cnt <= burst_cnt + BW'(1);
        end
        default: ;
      endcase
    end
  end

  // capture the preempted op; validity lives in park_vld
  always_ff @(posedge clk_i) begin
    if (s_rdy_i && is_pre && !rst_i) begin
      park_op[gnt]   <= cur_op;
      park_addr[gnt] <= addr_a[gnt];
      park_data[gnt] <= data_a[gnt];
      park_sel[gnt]  <= sel_a[gnt];
    end
  end

endmodule

// File: tb/tb_pi1_rr_arbiter.sv
// tb_pi1_rr_arbiter: directed vectors for the PI1 arbiter.
// Two instances: 2 masters/burst 4 and 3 masters/burst 1.
module tb_pi1_rr_arbiter;

  localparam int AW = 30;
  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] RD  = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // instance A: 2 masters, MAXBURST 4
  logic        rst_a = 1'b1;
  logic [3:0]  a_op = '0;
  logic [59:0] a_addr = {30'h20, 30'h10};
  logic [63:0] a_data = {32'h55, 32'h1111_1111};
  logic [7:0]  a_sel = 8'hFF;
  logic [63:0] a_mdata;
  logic [1:0]  a_rdy;
  logic [1:0]  a_sop;
  logic [AW-1:0] a_saddr;
  logic [31:0] a_sdata;
  logic [3:0]  a_ssel;
  logic [31:0] a_sdi = '0;
  logic        a_srdy = 1'b1;

  pi1_rr_arbiter #(
    .ARCHBITSZ(32), .MSTRCOUNT(2), .MAXBURST(4)
  ) u_a (
    .clk_i(clk), .rst_i(rst_a),
    .m_op_i(a_op), .m_addr_i(a_addr),
    .m_data_i(a_data), .m_sel_i(a_sel),
    .m_data_o(a_mdata), .m_rdy_o(a_rdy),
    .s_op_o(a_sop), .s_addr_o(a_saddr),
    .s_data_o(a_sdata), .s_sel_o(a_ssel),
    .s_data_i(a_sdi), .s_rdy_i(a_srdy)
  );

  // instance B: 3 masters, MAXBURST 1
  logic        rst_b = 1'b1;
  logic [5:0]  b_op = {RD, RD, RD};
  logic [89:0] b_addr = {30'h300, 30'h200, 30'h100};
  logic [95:0] b_data = {32'h3, 32'h2, 32'h1};
  logic [11:0] b_sel = 12'hFFF;
  logic [95:0] b_mdata;
  logic [2:0]  b_rdy;
  logic [1:0]  b_sop;
  logic [AW-1:0] b_saddr;
  logic [31:0] b_sdata;
  logic [3:0]  b_ssel;
  logic [31:0] b_sdi = 32'h0BAD_F00D;
  logic        b_srdy = 1'b1;

  pi1_rr_arbiter #(
    .ARCHBITSZ(32), .MSTRCOUNT(3), .MAXBURST(1)
  ) u_b (
    .clk_i(clk), .rst_i(rst_b),
    .m_op_i(b_op), .m_addr_i(b_addr),
    .m_data_i(b_data), .m_sel_i(b_sel),
    .m_data_o(b_mdata), .m_rdy_o(b_rdy),
    .s_op_o(b_sop), .s_addr_o(b_saddr),
    .s_data_o(b_sdata), .s_sel_o(b_ssel),
    .s_data_i(b_sdi), .s_rdy_i(b_srdy)
  );

  typedef struct {
    logic          rst;
    logic          srdy;
    logic [1:0]    op0;
    logic [1:0]    op1;
    logic [31:0]   sd;
    logic [1:0]    rdy;
    logic [1:0]    sop;
    logic          chk;
    logic [AW-1:0] sa;
    logic [31:0]   sw;
    logic [31:0]   d0;
  } va_t;

  typedef struct {
    logic [2:0]    rdy;
    logic [1:0]    sop;
    logic          chk;
    logic [AW-1:0] sa;
  } vb_t;

  va_t va [29];
  vb_t vb [11];

  function automatic va_t mkva(
    logic rst, logic srdy, logic [1:0] op0, logic [1:0] op1,
    logic [31:0] sd, logic [1:0] rdy, logic [1:0] sop,
    logic chk, logic [AW-1:0] sa, logic [31:0] sw,
    logic [31:0] d0);
    va_t v;
    v.rst = rst; v.srdy = srdy; v.op0 = op0; v.op1 = op1;
    v.sd = sd; v.rdy = rdy; v.sop = sop; v.chk = chk;
    v.sa = sa; v.sw = sw; v.d0 = d0;
    return v;
  endfunction

  function automatic vb_t mkvb(
    logic [2:0] rdy, logic [1:0] sop, logic chk,
    logic [AW-1:0] sa);
    vb_t v;
    v.rdy = rdy; v.sop = sop; v.chk = chk; v.sa = sa;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic apply_a(input int i);
    logic [31:0] d1;
    rst_a  = va[i].rst;
    a_srdy = va[i].srdy;
    a_op   = {va[i].op1, va[i].op0};
    a_sdi  = va[i].sd;
    d1 = va[i].rdy[1] ? va[i].sd : 32'h0;
    @(negedge clk);
    chk($sformatf("a%0d rdy", i), 64'(a_rdy), 64'(va[i].rdy));
    chk($sformatf("a%0d sop", i), 64'(a_sop), 64'(va[i].sop));
    chk($sformatf("a%0d d0", i), 64'(a_mdata[31:0]),
        64'(va[i].d0));
    chk($sformatf("a%0d d1", i), 64'(a_mdata[63:32]), 64'(d1));
    if (va[i].chk) begin
      chk($sformatf("a%0d saddr", i), 64'(a_saddr),
          64'(va[i].sa));
      chk($sformatf("a%0d sdata", i), 64'(a_sdata),
          64'(va[i].sw));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    va[0]  = mkva(1,1,RD ,WR ,32'h0,2'b00,NOP,0,0,0,0);
    va[1]  = mkva(0,1,RD ,NOP,32'h0,2'b01,RD ,1,30'h10,
                  32'h1111_1111,0);
    va[2]  = mkva(0,1,NOP,NOP,32'hDEAD_BEEF,2'b01,NOP,0,0,0,
                  32'hDEAD_BEEF);
    va[3]  = mkva(0,1,NOP,WR ,32'h0,2'b01,NOP,0,0,0,0);
    va[4]  = mkva(0,1,NOP,WR ,32'h77,2'b10,WR ,1,30'h20,
                  32'h55,0);
    va[5]  = mkva(0,1,NOP,NOP,32'h0,2'b10,NOP,0,0,0,0);
    va[6]  = mkva(0,1,RD ,NOP,32'h0,2'b10,NOP,0,0,0,0);
    va[7]  = mkva(0,1,RD ,NOP,32'h1,2'b01,RD ,1,30'h10,
                  32'h1111_1111,32'h1);
    va[8]  = mkva(0,1,RD ,WR ,32'h2,2'b01,RD ,1,30'h10,
                  32'h1111_1111,32'h2);
    va[9]  = mkva(0,1,RD ,WR ,32'h3,2'b01,RD ,1,30'h10,
                  32'h1111_1111,32'h3);
    va[10] = mkva(0,1,RD ,WR ,32'h4,2'b01,NOP,0,0,0,32'h4);
    va[11] = mkva(0,1,NOP,WR ,32'h5,2'b10,WR ,1,30'h20,
                  32'h55,0);
    va[12] = mkva(0,1,NOP,NOP,32'h6,2'b10,NOP,0,0,0,0);
    va[13] = mkva(0,1,NOP,NOP,32'h7,2'b00,RD ,1,30'h10,
                  32'h1111_1111,0);
    va[14] = mkva(0,1,NOP,NOP,32'hCAFE_F00D,2'b01,NOP,0,0,0,
                  32'hCAFE_F00D);
    va[15] = mkva(0,1,RD ,NOP,32'h0,2'b01,RD ,1,30'h10,
                  32'h1111_1111,0);
    va[16] = mkva(0,1,RD ,WR ,32'h0,2'b01,RD ,1,30'h10,
                  32'h1111_1111,0);
    for (int i = 17; i <= 21; i++)
      va[i] = mkva(0,0,RD ,WR ,32'hBAD,2'b00,RD ,1,30'h10,
                   32'h1111_1111,0);
    va[22] = mkva(0,1,RD ,WR ,32'h9,2'b01,RD ,1,30'h10,
                  32'h1111_1111,32'h9);
    va[23] = mkva(0,1,RD ,WR ,32'hA,2'b01,NOP,0,0,0,32'hA);
    va[24] = mkva(0,1,NOP,NOP,32'h3,2'b01,NOP,0,0,0,32'h3);
    va[25] = mkva(0,1,NOP,WR ,32'h0,2'b01,NOP,0,0,0,0);
    va[26] = mkva(0,1,NOP,WR ,32'h0,2'b10,WR ,1,30'h20,
                  32'h55,0);
    va[27] = mkva(0,1,NOP,NOP,32'h0,2'b10,NOP,0,0,0,0);
    va[28] = mkva(0,1,NOP,NOP,32'h0,2'b10,NOP,0,0,0,0);

    vb[0]  = mkvb(3'b001, NOP, 0, 0);
    vb[1]  = mkvb(3'b010, NOP, 0, 0);
    vb[2]  = mkvb(3'b100, NOP, 0, 0);
    vb[3]  = mkvb(3'b000, RD , 1, 30'h100);
    vb[4]  = mkvb(3'b001, NOP, 0, 0);
    vb[5]  = mkvb(3'b000, RD , 1, 30'h200);
    vb[6]  = mkvb(3'b010, NOP, 0, 0);
    vb[7]  = mkvb(3'b000, RD , 1, 30'h300);
    vb[8]  = mkvb(3'b100, NOP, 0, 0);
    vb[9]  = mkvb(3'b000, RD , 1, 30'h100);
    vb[10] = mkvb(3'b001, NOP, 0, 0);

    for (int i = 0; i <= 23; i++) apply_a(i);

    // m1 live WR under grant 1 with m0's op parked
    chk("pre-rst rdy", 64'(a_rdy), 64'(2'b10));
    chk("pre-rst sop", 64'(a_sop), 64'(WR));
    #2;
    rst_a = 1'b1;
    #1;
    chk("async-rst rdy", 64'(a_rdy), 64'(2'b00));
    chk("async-rst sop", 64'(a_sop), 64'(NOP));
    chk("async-rst mdata", a_mdata, 64'h0);
    @(posedge clk);
    #1;
    rst_a = 1'b0;

    for (int i = 24; i <= 28; i++) apply_a(i);

    rst_b = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("b%0d rdy", c), 64'(b_rdy), 64'(vb[c].rdy));
      chk($sformatf("b%0d sop", c), 64'(b_sop), 64'(vb[c].sop));
      if (vb[c].chk)
        chk($sformatf("b%0d saddr", c), 64'(b_saddr),
            64'(vb[c].sa));
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
